wb_check_monitor: RTL

// - Synthesizable self-check stage downstream of the Riscv151 writeback port: snoops every regfile write, keeps a shadow regfile,
//   and runs a queue of checks "wait until flag reg == F, then reg R must == V". Gives on-board pass/fail for assembly tests.
// - Sits beside CPU (fed by dpath writeback signals); results drive LEDs/UART status in FPGA top and are readable from benches.

---
 rtl/wb_check_pkg.sv | 33 +++
 rtl/chk_fifo.sv | 70 +++++++
 rtl/wb_check_monitor.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/wb_check_pkg.sv
// Shared types and constants for the writeback self-check monitor.
package wb_check_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned TESTNUM_W  = 11;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FLAG,
        CHECK,
        DONE,
        FAIL
    } state_t;

    // One queued check: wait for flag, then compare reg_idx against value.
    typedef struct packed {
        logic [XLEN-1:0]       flag;
        logic [REG_ADDR_W-1:0] reg_idx;
        logic [XLEN-1:0]       value;
        logic [TESTNUM_W-1:0]  num;
        logic                  last;
    } chk_entry_t;

    localparam int unsigned CHK_ENTRY_W = $bits(chk_entry_t);

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [TESTNUM_W-1:0] sat_inc(input logic [TESTNUM_W-1:0] v);
        return (v == '1) ? v : v + TESTNUM_W'(1);
    endfunction

endpackage

// File: rtl/chk_fifo.sv
// Synchronous FIFO holding pending check entries; show-ahead read port.
module chk_fifo
    import wb_check_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [CHK_ENTRY_W-1:0] wdata,
    input  logic                   pop,
    output logic [CHK_ENTRY_W-1:0] rdata,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CHK_ENTRY_W-1:0] mem_q [DEPTH];
    logic [CHK_ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   wr_en, rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // Pointer/count/storage update; a pop frees the slot a same-cycle push may take.
    always_comb begin
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_check_monitor.sv
// Writeback snooper: shadow regfile plus a queue of "wait for flag, then
// compare register" checks, producing sticky pass/fail status.
module wb_check_monitor
    import wb_check_pkg::*;
#(
    parameter int unsigned FLAG_REG       = 20,
    parameter int unsigned CHK_DEPTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  chk_valid,
    output logic                  chk_ready,
    input  logic [XLEN-1:0]       chk_flag,
    input  logic [REG_ADDR_W-1:0] chk_reg,
    input  logic [XLEN-1:0]       chk_value,
    input  logic [TESTNUM_W-1:0]  chk_num,
    input  logic                  chk_last,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [TESTNUM_W-1:0]  fail_num,
    output logic [XLEN-1:0]       fail_got,
    output logic [TESTNUM_W-1:0]  checks_passed
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REG_ADDR_W-1:0] FLAG_IDX   = REG_ADDR_W'(FLAG_REG);

    // Shadow register file
    logic [XLEN-1:0] shadow_q [NUM_REGS];
    logic [XLEN-1:0] shadow_d [NUM_REGS];

    // Check queue
    chk_entry_t             push_entry;
    logic [CHK_ENTRY_W-1:0] fifo_rdata;
    logic                   fifo_full, fifo_empty, fifo_pop, fifo_push;

    // FSM and status
    state_t                state_q, state_d;
    chk_entry_t            entry_q, entry_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic                  timeout_q, timeout_d;
    logic [TESTNUM_W-1:0]  fail_num_q, fail_num_d;
    logic [XLEN-1:0]       fail_got_q, fail_got_d;
    logic [TESTNUM_W-1:0]  passed_q, passed_d;
    logic [XLEN-1:0]       flag_val, chk_val;

    assign chk_ready  = !fifo_full;
    assign fifo_push  = chk_valid && chk_ready;
    assign push_entry = '{flag: chk_flag, reg_idx: chk_reg, value: chk_value,
                          num: chk_num, last: chk_last};

    chk_fifo #(
        .DEPTH(CHK_DEPTH)
    ) u_chk_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM reads registered shadow values, so same-cycle writebacks are not yet visible.
    assign flag_val = shadow_q[FLAG_IDX];
    assign chk_val  = shadow_q[entry_q.reg_idx];

    // Shadow regfile next state; x0 is never written so it stays zero.
    always_comb begin
        shadow_d = shadow_q;
        if (wb_we && (wb_addr != '0)) begin
            shadow_d[wb_addr] = wb_data;
        end
    end

    // Shadow regfile registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
        end
    end

    // Check sequencer next state and sticky status; the head entry stays
    // queued while waiting and is popped only when its compare begins.
    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        timer_d    = timer_q;
        fifo_pop   = 1'b0;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        timeout_d  = timeout_q;
        fail_num_d = fail_num_q;
        fail_got_d = fail_got_q;
        passed_d   = passed_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    entry_d = chk_entry_t'(fifo_rdata);
                    timer_d = '0;
                    state_d = WAIT_FLAG;
                end
            end
            WAIT_FLAG: begin
                if (flag_val == entry_q.flag) begin
                    fifo_pop = 1'b1;
                    state_d  = CHECK;
                end else if (timer_q == TIMER_LAST) begin
                    state_d    = FAIL;
                    done_d     = 1'b1;
                    fail_d     = 1'b1;
                    timeout_d  = 1'b1;
                    fail_num_d = entry_q.num;
                    fail_got_d = flag_val;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            CHECK: begin
                if (chk_val == entry_q.value) begin
                    passed_d = sat_inc(passed_q);
                    if (entry_q.last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d    = FAIL;
                    done_d     = 1'b1;
                    fail_d     = 1'b1;
                    fail_num_d = entry_q.num;
                    fail_got_d = chk_val;
                end
            end
            DONE:    state_d = DONE;
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            entry_q    <= '0;
            timer_q    <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            fail_num_q <= '0;
            fail_got_q <= '0;
            passed_q   <= '0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            timer_q    <= timer_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
            fail_num_q <= fail_num_d;
            fail_got_q <= fail_got_d;
            passed_q   <= passed_d;
        end
    end

    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign timeout       = timeout_q;
    assign fail_num      = fail_num_q;
    assign fail_got      = fail_got_q;
    assign checks_passed = passed_q;

endmodule
